// File: rtl/delay_stop_gen_pkg.sv
// -----------------------------------------------------------------------------
// delay_stop_gen_pkg
// Shared helpers for the fetch-stage stop-window generator.
//   cnt_width(n) : bits needed to hold the values 0..n, never less than 1.
// -----------------------------------------------------------------------------
package delay_stop_gen_pkg;

  function automatic int cnt_width(input int n);
    int w;
    w = (n < 1) ? 1 : $clog2(n + 1);
    return w;
  endfunction

endpackage

// File: rtl/delay_stop_gen.sv
// -----------------------------------------------------------------------------
// delay_stop_gen
// Opens a registered "stop" window of STOP_CYCLES cycles after each redirect
// request, so fetch/decode can squash wrong-path instructions. A stall freezes
// the window. A new redirect reloads the window; it does not add to it.
//
// Parameters
//   STOP_CYCLES : cycles of stop per trigger (0..255; 0 keeps stop low)
//   CNT_W       : remaining-cycle counter width, derived from STOP_CYCLES
// Ports
//   clk   in  : clock, rising edge
//   reset in  : synchronous active-high reset
//   stall in  : holds the countdown
//   delay in  : redirect request, level-sampled every edge
//   stop  out : high while a stop window is active (register decode only)
// -----------------------------------------------------------------------------
module delay_stop_gen
  import delay_stop_gen_pkg::*;
#(
  parameter int STOP_CYCLES = 1,
  parameter int CNT_W       = cnt_width(STOP_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic delay,
  output logic stop
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STOP_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Priority below reset: delay reloads even while stalled, so a redirect
  // that arrives during a freeze is never dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (delay) begin
      cnt_d = RELOAD;
    end else if (!stall && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stop = (cnt_q != '0);

  a_cnt_range : assert property (@(posedge clk) int'(cnt_q) <= STOP_CYCLES)
    else $error("delay_stop_gen: counter above STOP_CYCLES");

  a_reset_clears : assert property (@(posedge clk) reset |=> !stop)
    else $error("delay_stop_gen: stop high after reset edge");

endmodule

// File: tb/tb_delay_stop_gen.sv
// -----------------------------------------------------------------------------
// tb_delay_stop_gen
// Three instances (STOP_CYCLES = 0, 1, 3) share one stimulus stream. Each
// sampled edge is logged; the expected stop values are derived from the input
// history (last reset/delay event, then count of unstalled edges since it)
// and queued. A separate monitor pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_delay_stop_gen;

  logic clk = 1'b0;
  logic reset, stall, delay;
  logic stop0, stop1, stop3;

  always #5 clk = ~clk;

  delay_stop_gen #(.STOP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .delay(delay), .stop(stop0));
  delay_stop_gen #(.STOP_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .delay(delay), .stop(stop1));
  delay_stop_gen #(.STOP_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .stall(stall), .delay(delay), .stop(stop3));

  typedef struct {
    int       edge_idx;
    logic [2:0] exp;   // {N=3, N=1, N=0}
  } exp_t;

  exp_t sb_q[$];
  bit   rst_h[$];
  bit   dly_h[$];
  bit   stl_h[$];

  int checks = 0;
  int errors = 0;

  // Expected stop after edge k for a window length of n cycles.
  function automatic bit model_stop(input int n, input int k);
    int unstalled;
    if (n == 0) return 1'b0;
    for (int j = k; j >= 0; j--) begin
      if (rst_h[j]) return 1'b0;
      if (dly_h[j]) begin
        unstalled = 0;
        for (int m = j + 1; m <= k; m++)
          if (!stl_h[m]) unstalled++;
        return (unstalled < n);
      end
    end
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit s, input bit d);
    exp_t e;
    int   k;
    @(negedge clk);
    reset = r;
    stall = s;
    delay = d;
    @(posedge clk);
    rst_h.push_back(r);
    stl_h.push_back(s);
    dly_h.push_back(d);
    k = rst_h.size() - 1;
    e.edge_idx = k;
    e.exp = {model_stop(3, k), model_stop(1, k), model_stop(0, k)};
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are registered, sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (stop0 !== e.exp[0]) begin
          errors++;
          $display("FAIL stop_n0 edge %0d: got %b expected %b", e.edge_idx, stop0, e.exp[0]);
        end
        checks++;
        if (stop1 !== e.exp[1]) begin
          errors++;
          $display("FAIL stop_n1 edge %0d: got %b expected %b", e.edge_idx, stop1, e.exp[1]);
        end
        checks++;
        if (stop3 !== e.exp[2]) begin
          errors++;
          $display("FAIL stop_n3 edge %0d: got %b expected %b", e.edge_idx, stop3, e.exp[2]);
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    stall = 1'b0;
    delay = 1'b1;

    // Reset held two edges with delay high, then released with delay low.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(4);

    // Basic window.
    step(1'b0, 1'b0, 1'b1);
    idle(5);

    // Stall freeze inside the window.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(5);

    // Retrigger.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(5);

    // Retrigger while stalled.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(5);

    // Reset mid-window.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(5);

    // Delay held high for ten edges.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    idle(5);

    // Alternating delay.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, (i % 2) == 0);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(39) == 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0));
    idle(5);

    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_stop_gen.md
Name: delay_stop_gen

Overview:
- Generates a registered "stop" window of fixed length after each redirect request (`delay`).
- Lets the fetch stage squash or hold the instructions fetched on the wrong path after a branch or alternate-PC request.
- Sits beside the instruction-fetch stage: `delay` is driven by the alternate-PC request and `stop` feeds fetch/decode squash logic.
- A `stall` input freezes the window while the pipeline is frozen.

Parameters:
- STOP_CYCLES, default 1: number of consecutive cycles `stop` is asserted per trigger. Legal range 0..255; 0 means `stop` is permanently 0.
- CNT_W, default $clog2(STOP_CYCLES+1) (minimum 1): width of the internal remaining-cycle counter. Derived; never overridden independently.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze request; holds the countdown.
- delay  input  1  trigger (redirect request), level-sampled each rising edge.
- stop  output  1  high while a stop window is active.

Behaviour:
- State: one counter `cnt` [CNT_W-1:0], the number of remaining stop cycles.
- `stop` = (cnt != 0), decoded directly from the register. There is no combinational path from any input to `stop`.
- Priority at each rising edge, highest first: reset, then delay, then stall, then count.
  - reset=1: cnt <= 0. `stop` reads 0 in the following cycle, including mid-window; the window is abandoned. Reset value of `stop` = 0.
  - delay=1 (reset=0): cnt <= STOP_CYCLES, regardless of stall and current cnt.
    - Retrigger during an active window reloads the counter and extends the window (not additive).
    - A delay during stall is never lost.
  - stall=1, delay=0: cnt holds, so `stop` holds its value.
  - Otherwise: if cnt != 0 then cnt <= cnt - 1, else cnt stays 0.
- Latency: delay sampled high at edge k gives `stop`=1 for exactly STOP_CYCLES cycles, i.e. the cycles following edges k..k+STOP_CYCLES-1. This assumes no stall or retrigger in between.
- Each stalled edge inside the window extends it by one cycle.
- STOP_CYCLES=0: cnt is constant 0 and `stop`=0 forever; delay and stall have no effect.
- Counter never underflows and never exceeds STOP_CYCLES.
- Inputs are not edge-detected: delay held high for N edges keeps reloading, so `stop` stays high until STOP_CYCLES cycles after the last high sample.
- `delay` and `stall` may be X only while reset=1.
- Simulation assertions:
  - cnt <= STOP_CYCLES at all times.
  - `stop`=0 on the cycle after any reset edge.

Decomposition:
- No shared package content is needed beyond a common clog2 helper, if the team package already provides one.
- Single flat module; no sub-module warranted.
- Counter and decode live in one always_ff block plus one continuous assign.

Test Plan:
- Reset: hold reset=1 for 2 cycles with delay=1 -> stop=0 throughout and on the first cycle after reset drops, provided delay=0 at that edge.
- Basic window, STOP_CYCLES=3: single-cycle delay pulse at edge 5 -> stop=1 after edges 5, 6, 7 and stop=0 after edge 8.
- Stall freeze, STOP_CYCLES=3: pulse at edge 5, stall=1 on edges 6-7 -> stop high after edges 5 through 9 (5 cycles), low after edge 10.
- Retrigger and delay-over-stall, STOP_CYCLES=3:
  - pulse at edge 5, pulse again at edge 6 -> stop high after edges 5 through 8, low after edge 9.
  - repeat the retrigger case with stall=1 at edge 6 -> same result.
- Reset mid-window, STOP_CYCLES=3: pulse at edge 5, reset=1 at edge 6 -> stop=0 from the cycle after edge 6; no residual window after reset releases.
- Degenerate STOP_CYCLES=0 and default STOP_CYCLES=1:
  - STOP_CYCLES=0, delay held high for 10 cycles -> stop always 0.
  - STOP_CYCLES=1, alternating delay 1/0 -> stop equals delay delayed by one cycle.
